jtag_tap_ctrl: RTL and testbench

JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

---
 rtl/jtag_tap_pkg.sv | 39 +++
 rtl/jtag_tap_fsm.sv | 51 +++++
 rtl/jtag_tap_ctrl.sv | 128 ++++++++++++
 tb/tb_jtag_tap_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: state encoding, instruction opcodes, IR width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package jtag_tap_pkg;

    localparam int IR_LEN = 4;

    // 4-bit encoding of the 16 TAP controller states
    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'hF,
        RUN_TEST_IDLE    = 4'hC,
        SELECT_DR_SCAN   = 4'h7,
        CAPTURE_DR       = 4'h6,
        SHIFT_DR         = 4'h2,
        EXIT1_DR         = 4'h1,
        PAUSE_DR         = 4'h3,
        EXIT2_DR         = 4'h0,
        UPDATE_DR        = 4'h5,
        SELECT_IR_SCAN   = 4'h4,
        CAPTURE_IR       = 4'hE,
        SHIFT_IR         = 4'hA,
        EXIT1_IR         = 4'h9,
        PAUSE_IR         = 4'hB,
        EXIT2_IR         = 4'h8,
        UPDATE_IR        = 4'hD
    } tap_state_e;

    // Instruction opcodes; anything not listed behaves as BYPASS
    localparam logic [3:0] OP_EXTEST         = 4'b0000;
    localparam logic [3:0] OP_SAMPLE_PRELOAD = 4'b0001;
    localparam logic [3:0] OP_IDCODE         = 4'b0010;
    localparam logic [3:0] OP_DEBUG          = 4'b1000;
    localparam logic [3:0] OP_MBIST          = 4'b1001;
    localparam logic [3:0] OP_BYPASS         = 4'b1111;

    // Fixed pattern loaded into the IR shift register in Capture-IR
    localparam logic [3:0] IR_CAPTURE = 4'b0101;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP state machine, one TMS-driven transition per tck edge.
// Latency: state register updates on each tck rising edge.
// Backpressure: none; paced purely by tck.
module jtag_tap_fsm
    import jtag_tap_pkg::*;
(
    input  logic       tck,
    input  logic       trst_n,
    input  logic       tms,
    output logic [3:0] state
);

    tap_state_e state_q;
    tap_state_e state_d;

    // State register; synchronous reset forces Test-Logic-Reset
    always_ff @(posedge tck) begin
        if (!trst_n) begin
            state_q <= TEST_LOGIC_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Standard TAP transition graph selected by tms
    always_comb begin
        state_d = state_q;
        case (state_q)
            TEST_LOGIC_RESET: state_d = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   state_d = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       state_d = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         state_d = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         state_d = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         state_d = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         state_d = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   state_d = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       state_d = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         state_d = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         state_d = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         state_d = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         state_d = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          state_d = TEST_LOGIC_RESET;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller: IR/DR scan datapath, instruction decode and tdo mux.
// Latency: registers update on tck rising edge; tdo is combinational from state.
// Backpressure: none; every tck edge advances the scan by one bit.
module jtag_tap_ctrl #(
    parameter logic [31:0] IDCODE_VALUE = 32'h149511C3,
    parameter int          IR_LEN       = 4
) (
    input  logic tck,
    input  logic trst_n,
    input  logic tms,
    input  logic tdi,
    output logic tdo,
    output logic tdo_oe,
    input  logic debug_tdo,
    output logic debug_select,
    output logic test_logic_reset,
    output logic run_test_idle,
    output logic capture_dr,
    output logic shift_dr,
    output logic pause_dr,
    output logic update_dr
);

    import jtag_tap_pkg::*;

    logic [3:0] state;
    tap_state_e tap_state;

    logic [IR_LEN-1:0] ir_shift_q, ir_shift_d;
    logic [IR_LEN-1:0] ir_q, ir_d;
    logic [31:0]       idcode_sr_q, idcode_sr_d;
    logic              bypass_q, bypass_d;

    logic sel_idcode;
    logic sel_debug;
    logic enter_tlr;

    jtag_tap_fsm u_fsm (
        .tck    (tck),
        .trst_n (trst_n),
        .tms    (tms),
        .state  (state)
    );

    assign tap_state = tap_state_e'(state);

    // Only IDCODE and DEBUG have dedicated DR paths; all else uses the bypass bit
    assign sel_idcode = (ir_q == IR_LEN'(OP_IDCODE));
    assign sel_debug  = (ir_q == IR_LEN'(OP_DEBUG));

    // The edge that lands in (or stays in) Test-Logic-Reset also resets the IR
    assign enter_tlr = tms && (tap_state == TEST_LOGIC_RESET ||
                               tap_state == SELECT_IR_SCAN);

    // Next-state of the IR and DR registers for the current TAP state
    always_comb begin
        ir_shift_d  = ir_shift_q;
        ir_d        = ir_q;
        idcode_sr_d = idcode_sr_q;
        bypass_d    = bypass_q;
        case (tap_state)
            CAPTURE_IR: ir_shift_d = IR_LEN'(IR_CAPTURE);
            SHIFT_IR:   ir_shift_d = {tdi, ir_shift_q[IR_LEN-1:1]};
            UPDATE_IR:  ir_d       = ir_shift_q;
            CAPTURE_DR: begin
                if (sel_idcode) begin
                    idcode_sr_d = IDCODE_VALUE;
                end else if (!sel_debug) begin
                    bypass_d = 1'b0;
                end
            end
            SHIFT_DR: begin
                if (sel_idcode) begin
                    idcode_sr_d = {tdi, idcode_sr_q[31:1]};
                end else if (!sel_debug) begin
                    bypass_d = tdi;
                end
            end
            default: ;
        endcase
        if (enter_tlr) begin
            ir_d = IR_LEN'(OP_IDCODE);
        end
    end

    // Datapath registers; reset aborts any scan and restores IDCODE
    always_ff @(posedge tck) begin
        if (!trst_n) begin
            ir_shift_q  <= '0;
            ir_q        <= IR_LEN'(OP_IDCODE);
            idcode_sr_q <= '0;
            bypass_q    <= 1'b0;
        end else begin
            ir_shift_q  <= ir_shift_d;
            ir_q        <= ir_d;
            idcode_sr_q <= idcode_sr_d;
            bypass_q    <= bypass_d;
        end
    end

    // tdo presents the bit that the next edge shifts out; quiet outside shifts
    always_comb begin
        tdo    = 1'b0;
        tdo_oe = 1'b0;
        if (tap_state == SHIFT_IR) begin
            tdo    = ir_shift_q[0];
            tdo_oe = 1'b1;
        end else if (tap_state == SHIFT_DR) begin
            tdo_oe = 1'b1;
            if (sel_idcode) begin
                tdo = idcode_sr_q[0];
            end else if (sel_debug) begin
                tdo = debug_tdo;
            end else begin
                tdo = bypass_q;
            end
        end
    end

    assign debug_select     = sel_debug;
    assign test_logic_reset = (tap_state == TEST_LOGIC_RESET);
    assign run_test_idle    = (tap_state == RUN_TEST_IDLE);
    assign capture_dr       = (tap_state == CAPTURE_DR);
    assign shift_dr         = (tap_state == SHIFT_DR);
    assign pause_dr         = (tap_state == PAUSE_DR);
    assign update_dr        = (tap_state == UPDATE_DR);

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl: vector table, directed scans, random vs model.
// Latency: n/a.
// Backpressure: n/a.
module tb_jtag_tap_ctrl;

    localparam logic [31:0] IDCODE = 32'h149511C3;

    // Abstract state numbering for the reference model
    localparam int S_TLR = 0,  S_RTI = 1,  S_SDR = 2,   S_CDR = 3;
    localparam int S_SHDR = 4, S_E1DR = 5, S_PDR = 6,   S_E2DR = 7;
    localparam int S_UDR = 8,  S_SIR = 9,  S_CIR = 10,  S_SHIR = 11;
    localparam int S_E1IR = 12, S_PIR = 13, S_E2IR = 14, S_UIR = 15;

    logic tck = 1'b0;
    logic trst_n, tms, tdi, debug_tdo;
    logic tdo, tdo_oe, debug_select;
    logic tlr, rti, cdr, sdr, pdr, udr;

    int n_checks = 0;
    int n_fail   = 0;

    int nxt0[16];
    int nxt1[16];

    int          m_st;
    int          m_ir;
    int          m_irsh;
    logic [31:0] m_id;
    logic        m_byp;

    typedef struct {
        logic       trst_n;
        logic       tms;
        logic [5:0] dec;
        logic       oe;
        logic       tdo;
    } vec_t;

    vec_t vt[13];

    jtag_tap_ctrl #(.IDCODE_VALUE(IDCODE), .IR_LEN(4)) dut (
        .tck              (tck),
        .trst_n           (trst_n),
        .tms              (tms),
        .tdi              (tdi),
        .tdo              (tdo),
        .tdo_oe           (tdo_oe),
        .debug_tdo        (debug_tdo),
        .debug_select     (debug_select),
        .test_logic_reset (tlr),
        .run_test_idle    (rti),
        .capture_dr       (cdr),
        .shift_dr         (sdr),
        .pause_dr         (pdr),
        .update_dr        (udr)
    );

    always #5 tck = ~tck;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    function automatic logic [5:0] dec();
        return {tlr, rti, cdr, sdr, pdr, udr};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one bit, sample tdo just before the edge, then step past the edge
    task automatic tick(input logic t_ms, input logic t_di, output logic tdo_b);
        tms = t_ms;
        tdi = t_di;
        #2;
        tdo_b = tdo;
        @(posedge tck);
        #1;
    endtask

    // From Run-Test/Idle: full DR scan of n bits, back to Run-Test/Idle
    task automatic scan_dr(input logic [31:0] din, input int n, output logic [31:0] dout);
        logic b;
        dout = '0;
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
        tick(1'b0, 1'b0, b);
        for (int i = 0; i < n; i++) begin
            tick(i == n - 1, din[i], b);
            dout[i] = b;
        end
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
    endtask

    // From Run-Test/Idle: full 4-bit IR scan, back to Run-Test/Idle
    task automatic scan_ir(input logic [3:0] din, output logic [3:0] dout);
        logic b;
        dout = '0;
        tick(1'b1, 1'b0, b);
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
        tick(1'b0, 1'b0, b);
        for (int i = 0; i < 4; i++) begin
            tick(i == 3, din[i], b);
            dout[i] = b;
        end
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
    endtask

    // Reference model: one tck edge worth of TAP behaviour
    task automatic model_step(input logic rst_n, input logic t, input logic d);
        if (!rst_n) begin
            m_st = S_TLR; m_ir = 2; m_irsh = 0; m_id = '0; m_byp = 1'b0;
            return;
        end
        case (m_st)
            S_CIR:  m_irsh = 5;
            S_SHIR: m_irsh = (m_irsh >> 1) | (int'(d) << 3);
            S_UIR:  m_ir = m_irsh;
            S_CDR: begin
                if (m_ir == 2) m_id = IDCODE;
                else if (m_ir != 8) m_byp = 1'b0;
            end
            S_SHDR: begin
                if (m_ir == 2) m_id = {d, m_id[31:1]};
                else if (m_ir != 8) m_byp = d;
            end
            default: ;
        endcase
        m_st = t ? nxt1[m_st] : nxt0[m_st];
        if (m_st == S_TLR) m_ir = 2;
    endtask

    function automatic logic model_tdo(input logic dbg);
        if (m_st == S_SHIR) return m_irsh[0];
        if (m_st == S_SHDR) begin
            if (m_ir == 2) return m_id[0];
            if (m_ir == 8) return dbg;
            return m_byp;
        end
        return 1'b0;
    endfunction

    function automatic logic [5:0] model_dec();
        return {m_st == S_TLR, m_st == S_RTI, m_st == S_CDR,
                m_st == S_SHDR, m_st == S_PDR, m_st == S_UDR};
    endfunction

    initial begin
        logic        b;
        logic [31:0] d32;
        logic [3:0]  d4;
        logic        dv, tv, iv;

        nxt0 = '{S_RTI, S_RTI, S_CDR, S_SHDR, S_SHDR, S_PDR, S_PDR, S_SHDR,
                 S_RTI, S_CIR, S_SHIR, S_SHIR, S_PIR, S_PIR, S_SHIR, S_RTI};
        nxt1 = '{S_TLR, S_SDR, S_SIR, S_E1DR, S_E1DR, S_UDR, S_E2DR, S_UDR,
                 S_SDR, S_TLR, S_E1IR, S_E1IR, S_UIR, S_E2IR, S_UIR, S_SDR};

        vt[0]  = '{1'b0, 1'b1, 6'b100000, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 6'b010000, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 1'b1, 6'b000000, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 6'b001000, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 6'b000100, 1'b1, 1'b1};
        vt[5]  = '{1'b1, 1'b1, 6'b000000, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 6'b000010, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 1'b1, 6'b000000, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 1'b1, 6'b000001, 1'b0, 1'b0};
        vt[9]  = '{1'b1, 1'b0, 6'b010000, 1'b0, 1'b0};
        vt[10] = '{1'b1, 1'b1, 6'b000000, 1'b0, 1'b0};
        vt[11] = '{1'b1, 1'b1, 6'b000000, 1'b0, 1'b0};
        vt[12] = '{1'b1, 1'b1, 6'b100000, 1'b0, 1'b0};

        trst_n = 1'b0; tms = 1'b1; tdi = 1'b0; debug_tdo = 1'b1;
        @(posedge tck);
        #1;

        // State walk: decodes, output enable, tdo after each edge
        for (int i = 0; i < 13; i++) begin
            trst_n = vt[i].trst_n;
            tick(vt[i].tms, 1'b0, b);
            chk($sformatf("vec%0d_dec", i), dec(), vt[i].dec);
            chk($sformatf("vec%0d_oe", i), tdo_oe, vt[i].oe);
            chk($sformatf("vec%0d_tdo", i), tdo, vt[i].tdo);
            chk($sformatf("vec%0d_dsel", i), debug_select, 1'b0);
        end
        trst_n = 1'b1;
        debug_tdo = 1'b0;

        // IDCODE read after reset, and again to show the IR stays IDCODE
        tick(1'b0, 1'b0, b);
        chk("rti_after_tlr", run_test_idle_w(), 1'b1);
        scan_dr(32'h0, 32, d32);
        chk("idcode_scan", d32, IDCODE);
        scan_dr(32'h0, 32, d32);
        chk("idcode_rescan", d32, IDCODE);

        // IR capture pattern, then BYPASS delays data by one bit
        scan_ir(4'b1111, d4);
        chk("ir_capture", d4, 4'b0101);
        scan_dr(32'hA5, 8, d32);
        chk("bypass_a5", d32, 32'h4A);
        chk("bypass_dsel", debug_select, 1'b0);

        // DEBUG: tdo follows debug_tdo in Shift-DR, quiet in Pause-DR
        scan_ir(4'b1000, d4);
        chk("debug_select_set", debug_select, 1'b1);
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
        tick(1'b0, 1'b0, b);
        for (int i = 0; i < 8; i++) begin
            dv = 1'($urandom);
            debug_tdo = dv;
            tick(i == 7, 1'b0, b);
            chk($sformatf("debug_follow%0d", i), b, dv);
        end
        tick(1'b0, 1'b0, b);
        debug_tdo = 1'b1;
        #1;
        chk("pause_dr_state", pdr, 1'b1);
        chk("pause_dr_tdo", tdo, 1'b0);
        tick(1'b1, 1'b0, b);
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
        debug_tdo = 1'b0;

        // TLR recovery from Pause-IR, passing through Update-IR on the way
        tick(1'b1, 1'b0, b);
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
        tick(1'b0, 1'b0, b);
        tick(1'b1, 1'b1, b);
        tick(1'b0, 1'b0, b);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, b);
        chk("tlr_recover", tlr, 1'b1);
        chk("tlr_recover_dsel", debug_select, 1'b0);
        tick(1'b0, 1'b0, b);
        scan_dr(32'h0, 32, d32);
        chk("tlr_recover_ir", d32, IDCODE);

        // Reset at bit 2 of an IR shift of 1000
        tick(1'b1, 1'b0, b);
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
        tick(1'b0, 1'b0, b);
        tick(1'b0, 1'b0, b);
        tick(1'b0, 1'b0, b);
        trst_n = 1'b0;
        tick(1'b0, 1'b0, b);
        trst_n = 1'b1;
        chk("midscan_tlr", tlr, 1'b1);
        chk("midscan_dsel", debug_select, 1'b0);
        chk("midscan_oe", tdo_oe, 1'b0);
        tick(1'b0, 1'b0, b);
        scan_dr(32'h0, 32, d32);
        chk("midscan_ir", d32, IDCODE);

        // Random traffic against the reference model
        trst_n = 1'b0;
        tick(1'b1, 1'b0, b);
        trst_n = 1'b1;
        model_step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 1500; i++) begin
            trst_n    = ($urandom_range(0, 99) != 0);
            tv        = ($urandom_range(0, 9) < 3);
            iv        = 1'($urandom);
            dv        = 1'($urandom);
            debug_tdo = dv;
            tick(tv, iv, b);
            chk("rnd_tdo", b, model_tdo(dv));
            model_step(trst_n, tv, iv);
            chk("rnd_dec", dec(), model_dec());
            chk("rnd_oe", tdo_oe, (m_st == S_SHIR || m_st == S_SHDR));
            chk("rnd_dsel", debug_select, (m_ir == 8));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    function automatic logic run_test_idle_w();
        return rti;
    endfunction

endmodule
